// File: rtl/stream_bit_counter_pkg.sv
// Shared definitions for the stream bit counter.
//   state_t : frame FSM states (IDLE, ACCUM, DONE)
//   clog2   : ceil(log2(v)) for width derivation; clog2(1) = 0
package stream_bit_counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (longint unsigned p = 1; p < longint'(v); p = p << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_popcount.sv
// Combinational population count.
//   din : W-bit input word
//   cnt : number of 1 bits in din, clog2(W+1) bits wide
module bit_popcount
  import stream_bit_counter_pkg::*;
#(
  parameter  int unsigned W  = 8,
  localparam int unsigned CW = clog2(W + 1)
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < W; i++) begin
      cnt = cnt + CW'(din[i]);
    end
  end

endmodule

// File: rtl/stream_bit_counter.sv
// Counts 1 and 0 bits over a frame of input beats and presents the totals
// as a single registered result with a valid/ready handshake.
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid/in_ready      : input beat handshake
//   in_data, in_last       : beat payload and end-of-frame marker
//   out_valid/out_ready    : result handshake
//   out_ones, out_zeroes   : 1-bit and 0-bit totals of the frame
//   out_words              : beats in the frame
//   out_trunc              : frame closed at MAX_WORDS without in_last
module stream_bit_counter
  import stream_bit_counter_pkg::*;
#(
  parameter  int unsigned DATA_W    = 8,
  parameter  int unsigned MAX_WORDS = 16,
  localparam int unsigned CNT_W     = clog2(DATA_W * MAX_WORDS + 1),
  localparam int unsigned WCNT_W    = clog2(MAX_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_ones,
  output logic [CNT_W-1:0]  out_zeroes,
  output logic [WCNT_W-1:0] out_words,
  output logic              out_trunc
);

  localparam int unsigned PC_W = clog2(DATA_W + 1);

  state_t            state;
  logic              rdy_en;
  logic [CNT_W-1:0]  acc_ones;
  logic [WCNT_W-1:0] acc_words;
  logic [PC_W-1:0]   pc;

  logic              accept;
  logic              close;
  logic [CNT_W-1:0]  sum_ones;
  logic [WCNT_W-1:0] sum_words;
  logic [CNT_W-1:0]  sum_zeroes;

  bit_popcount #(.W(DATA_W)) u_popcount (
    .din (in_data),
    .cnt (pc)
  );

  // rdy_en holds in_ready low during reset and releases it on the first
  // clock edge after rst_n deasserts.
  assign in_ready  = rdy_en && (state != DONE);
  assign out_valid = (state == DONE);

  always_comb begin
    accept     = in_valid && in_ready;
    sum_ones   = acc_ones + CNT_W'(pc);
    sum_words  = acc_words + WCNT_W'(1);
    close      = accept && (in_last || (sum_words == WCNT_W'(MAX_WORDS)));
    // words*DATA_W never exceeds DATA_W*MAX_WORDS, which CNT_W covers.
    sum_zeroes = CNT_W'(sum_words) * CNT_W'(DATA_W) - sum_ones;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rdy_en     <= 1'b0;
      acc_ones   <= '0;
      acc_words  <= '0;
      out_ones   <= '0;
      out_zeroes <= '0;
      out_words  <= '0;
      out_trunc  <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_ones  <= sum_ones;
            acc_words <= sum_words;
            if (close) begin
              state      <= DONE;
              out_ones   <= sum_ones;
              out_zeroes <= sum_zeroes;
              out_words  <= sum_words;
              out_trunc  <= !in_last;
            end else begin
              state <= ACCUM;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            acc_ones  <= '0;
            acc_words <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_bit_counter.sv
module tb_stream_bit_counter;

  localparam int MAXW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] out_ones;
  logic [5:0] out_zeroes;
  logic [2:0] out_words;
  logic       out_trunc;

  int n_checks = 0;
  int n_errors = 0;

  stream_bit_counter #(.DATA_W(8), .MAX_WORDS(MAXW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ones   (out_ones),
    .out_zeroes (out_zeroes),
    .out_words  (out_words),
    .out_trunc  (out_trunc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a frame is the list of accepted beats; results follow
  // from counting bits over that list.
  bit [7:0] q[$];
  bit       m_rdy_en = 1'b0;
  bit       m_done = 1'b0;
  int       m_ones = 0;
  int       m_zeroes = 0;
  int       m_words = 0;
  bit       m_trunc = 1'b0;

  function automatic int frame_ones(input bit [7:0] fq[$]);
    int s;
    s = 0;
    foreach (fq[i]) s += $countones(fq[i]);
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rdy_en <= 1'b0;
      m_done   <= 1'b0;
      q.delete();
    end else begin
      if (m_done) begin
        if (out_ready) begin
          m_done <= 1'b0;
          q.delete();
        end
      end else if (m_rdy_en && in_valid) begin
        q.push_back(in_data);
        if (in_last || q.size() == MAXW) begin
          m_done   <= 1'b1;
          m_ones   <= frame_ones(q);
          m_words  <= q.size();
          m_zeroes <= q.size() * 8 - frame_ones(q);
          m_trunc  <= !in_last;
        end
      end
      m_rdy_en <= 1'b1;
    end
  end

  always @(negedge clk) begin
    check("in_ready", in_ready, m_rdy_en && !m_done);
    check("out_valid", out_valid, m_done);
    if (m_done) begin
      check("model_ones", out_ones, m_ones);
      check("model_zeroes", out_zeroes, m_zeroes);
      check("model_words", out_words, m_words);
      check("model_trunc", out_trunc, m_trunc);
    end
  end

  task automatic send(input logic [7:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input string tag, input int ones, input int zeroes,
                               input int words, input logic trunc);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_ones"}, out_ones, ones);
    check({tag, "_zeroes"}, out_zeroes, zeroes);
    check({tag, "_words"}, out_words, words);
    check({tag, "_trunc"}, out_trunc, trunc);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_released"}, out_valid, 1'b0);
    check({tag, "_ready_again"}, in_ready, 1'b1);
  endtask

  initial begin
    int sent;
    int budget;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_ones", out_ones, 0);
    check("rst_zeroes", out_zeroes, 0);
    check("rst_words", out_words, 0);
    check("rst_trunc", out_trunc, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", in_ready, 1'b1);

    // Single-beat frame, result one cycle after the beat
    send(8'hA5, 1'b1);
    expect_result("single", 4, 4, 1, 1'b0);
    release_result("single");

    // Back-to-back three-beat frame
    send(8'hFF, 1'b0);
    send(8'h00, 1'b0);
    send(8'h0F, 1'b1);
    expect_result("b2b", 12, 12, 3, 1'b0);
    release_result("b2b");

    // Truncation at MAX_WORDS, then a new frame
    send(8'h01, 1'b0);
    send(8'h03, 1'b0);
    send(8'h07, 1'b0);
    send(8'h0F, 1'b0);
    expect_result("trunc", 10, 22, 4, 1'b1);
    release_result("trunc");
    send(8'hFF, 1'b1);
    expect_result("after_trunc", 8, 0, 1, 1'b0);
    release_result("after_trunc");

    // Backpressure: result held, input ignored
    send(8'h3C, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      in_last  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      expect_result("hold", 4, 4, 1, 1'b0);
      check("hold_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    release_result("hold");
    send(8'h01, 1'b1);
    expect_result("post_hold", 1, 7, 1, 1'b0);
    release_result("post_hold");

    // Reset mid-frame discards the partial frame
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_ones", out_ones, 0);
    check("midrst_zeroes", out_zeroes, 0);
    check("midrst_words", out_words, 0);
    check("midrst_trunc", out_trunc, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready_back", in_ready, 1'b1);
    send(8'hFF, 1'b1);
    expect_result("post_rst", 8, 0, 1, 1'b0);
    release_result("post_rst");

    // Random in_valid gaps over a four-beat frame of 8'h80
    sent = 0;
    budget = 0;
    while (sent < 4 && budget < 200) begin
      in_valid = 1'($urandom_range(0, 1));
      if (in_valid) begin
        in_data = 8'h80;
        in_last = (sent == 3);
      end else begin
        in_data = 8'($urandom);
        in_last = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      if (in_valid) sent++;
      budget++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("gaps_beats_sent", sent, 4);
    expect_result("gaps", 4, 28, 4, 1'b0);
    release_result("gaps");

    // Random traffic checked by the model each cycle
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("final_idle", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_bit_counter.md
STREAM_BIT_COUNTER -- requirements
Module: stream_bit_counter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: bits per input beat, legal range 2..64.
REQ-002 The block SHALL have parameter MAX_WORDS, default 16: the maximum number of beats per frame, legal range 1..1024.
REQ-003 The block SHALL derive the local constants CNT_W = clog2(DATA_W*MAX_WORDS+1) and WCNT_W = clog2(MAX_WORDS+1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the input beat is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts the input beat.
REQ-008 The block SHALL have port in_data, input, DATA_W bits: the beat payload.
REQ-009 The block SHALL have port in_last, input, 1 bit: the beat is the final beat of its frame.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the frame result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream logic accepts the result.
REQ-012 The block SHALL have port out_ones, output, CNT_W bits: the total count of 1 bits in the frame.
REQ-013 The block SHALL have port out_zeroes, output, CNT_W bits: the total count of 0 bits in the frame.
REQ-014 The block SHALL have port out_words, output, WCNT_W bits: the number of beats in the frame.
REQ-015 The block SHALL have port out_trunc, output, 1 bit: the frame was closed at MAX_WORDS without in_last.

Function
REQ-016 The block SHALL implement FSM states IDLE, ACCUM and DONE.
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM and SHALL be 0 in DONE.
REQ-018 A beat SHALL be accepted only in a cycle where in_valid and in_ready are both 1.
REQ-019 While in_ready is 0, in_data and in_last SHALL be ignored.
REQ-020 On each accepted beat, the ones accumulator SHALL add popcount(in_data) and the word counter SHALL add 1, both in the same cycle.
REQ-021 The block SHALL sustain one beat per cycle in ACCUM, with no bubbles.
REQ-022 From IDLE, an accepted beat with in_last=0 SHALL move the FSM to ACCUM.
REQ-023 From IDLE, an accepted beat with in_last=1 SHALL move the FSM directly to DONE, giving a one-beat frame.
REQ-024 From ACCUM, an accepted beat with in_last=1 SHALL move the FSM to DONE.
REQ-025 An accepted beat that is the MAX_WORDS-th beat of the frame SHALL move the FSM to DONE regardless of in_last; out_trunc SHALL be 1 if in_last was 0 and 0 otherwise.
REQ-026 Beats arriving after a truncation SHALL start a new frame.
REQ-027 out_valid SHALL be 1 exactly while the FSM is in DONE, which is the cycle after the closing beat is accepted (latency 1 cycle).
REQ-028 out_ones, out_zeroes, out_words and out_trunc SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-029 out_zeroes SHALL equal out_words*DATA_W - out_ones, computed at CNT_W width with no overflow by construction.
REQ-030 In DONE with out_ready=1, the FSM SHALL move to IDLE and clear the accumulators on that edge.
REQ-031 The next beat SHALL be acceptable no earlier than the following cycle, giving a minimum frame period of words+1 cycles.
REQ-032 out_ready asserted outside DONE SHALL have no effect.
REQ-033 An input of all zeros SHALL contribute 0 to out_ones and DATA_W to out_zeroes; an input of all ones SHALL contribute DATA_W to out_ones and 0 to out_zeroes.

Reset
REQ-034 While rst_n=0, the FSM SHALL be in IDLE and the accumulators, out_ones, out_zeroes, out_words, out_trunc and out_valid SHALL be 0.
REQ-035 While rst_n=0, in_ready SHALL be 0.
REQ-036 in_ready SHALL become 1 at the first rising clk edge after rst_n deasserts.
REQ-037 A reset mid-frame or in DONE SHALL discard the partial or pending result with no output handshake.

Structure
REQ-038 The package stream_bit_counter_pkg SHALL hold the FSM state enum (IDLE, ACCUM, DONE) and the clog2 width helper.
REQ-039 The combinational popcount SHALL be a sub-module bit_popcount with parameter W, input W bits and output clog2(W+1) bits, and SHALL contain no state.
REQ-040 All other logic, including the FSM, accumulators and output registers, SHALL reside in stream_bit_counter.

Verification (DATA_W=8, MAX_WORDS=4)
REQ-041 The bench SHALL drive a single beat 8'hA5 with last=1 and SHALL check that out_valid is 1 one cycle later with ones=4, zeroes=4, words=1, trunc=0.
REQ-042 The bench SHALL drive back-to-back beats FF, 00, 0F with last on the third beat and SHALL check ones=12, zeroes=12, words=3, trunc=0.
REQ-043 The bench SHALL drive four beats 01, 03, 07, 0F with no last and SHALL check ones=10, zeroes=22, words=4, trunc=1; a fifth beat SHALL start a new frame.
REQ-044 The bench SHALL hold out_ready=0 for 5 cycles in DONE and SHALL check that the outputs are stable, in_ready=0 and in_valid beats are ignored; after out_ready=1, it SHALL check that the next frame counts from zero.
REQ-045 The bench SHALL pulse rst_n=0 after 2 beats of a frame and SHALL check that all outputs are 0 and that a following 1-beat frame of FF gives ones=8, words=1.
REQ-046 The bench SHALL toggle in_valid randomly over a 4-beat frame of 8'h80 beats and SHALL check ones=4, zeroes=28, with only handshaked beats counted.
